// File: rtl/lj_r2_lut_addr_gen.sv
// LJ r2 -> coefficient ROM address generator.
// Decodes r2 into a segment/bin ROM address, carries the residual fraction and
// range flags alongside the fixed-latency ROM read, and buffers results in a
// small FWFT FIFO. Input flow control is credit based because the ROM pipe cannot stall.
module lj_r2_lut_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BIN_BITS   = 8,
  parameter int unsigned NUM_SEG    = 12,
  parameter int unsigned MIN_EXP    = 121,
  parameter int unsigned LUT_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  ivalid,
  output logic                  iready,
  input  logic [31:0]           ir2,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic                  lut_rden,
  input  logic [31:0]           lut_q,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [31:0]           ocoef,
  output logic [22-BIN_BITS:0]  odelta,
  output logic [1:0]            oflags
);

  localparam int unsigned DELTA_W = 23 - BIN_BITS;
  localparam int unsigned ENTRY_W = 32 + DELTA_W + 2;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SC_LEN  = LUT_LAT + 1;

  // Decode signals
  logic                  sign_c;
  logic [7:0]            exp_c;
  logic [22:0]           man_c;
  logic [7:0]            seg_c;
  logic [ADDR_WIDTH-1:0] dec_addr_c;
  logic [DELTA_W-1:0]    dec_delta_c;
  logic [1:0]            dec_flags_c;

  // Handshake
  logic                  accept_c;
  logic                  pop_c;
  logic                  push_c;
  logic [ENTRY_W-1:0]    push_data_c;
  logic [ENTRY_W-1:0]    head_c;

  // Address stage
  logic [ADDR_WIDTH-1:0] lut_address_q, lut_address_d;
  logic                  lut_rden_q, lut_rden_d;
  logic [DELTA_W-1:0]    as_delta_q, as_delta_d;
  logic [1:0]            as_flags_q, as_flags_d;

  // Sidecar aligned with the ROM read latency
  logic [SC_LEN-1:0]     sc_vld_q, sc_vld_d;
  logic [DELTA_W-1:0]    sc_delta_q [SC_LEN];
  logic [DELTA_W-1:0]    sc_delta_d [SC_LEN];
  logic [1:0]            sc_flags_q [SC_LEN];
  logic [1:0]            sc_flags_d [SC_LEN];

  // Output FIFO and credit counter
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      cnt_q, cnt_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  iready_q, iready_d;
  logic                  ovalid_q, ovalid_d;
  logic [31:0]           ocoef_q, ocoef_d;
  logic [DELTA_W-1:0]    odelta_q, odelta_d;
  logic [1:0]            oflags_q, oflags_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Split r2 into segment/bin address, residual fraction and range flags
  always_comb begin
    sign_c      = ir2[31];
    exp_c       = ir2[30:23];
    man_c       = ir2[22:0];
    seg_c       = exp_c - 8'(MIN_EXP);
    dec_addr_c  = '0;
    dec_delta_c = '0;
    dec_flags_c = 2'b00;
    if (sign_c || (9'(exp_c) < 9'(MIN_EXP))) begin
      dec_flags_c = 2'b01;
    end else if (9'(exp_c) >= 9'(MIN_EXP + NUM_SEG)) begin
      dec_flags_c = 2'b10;
    end else begin
      dec_addr_c  = (ADDR_WIDTH'(seg_c) << BIN_BITS) | ADDR_WIDTH'(man_c[22 -: BIN_BITS]);
      dec_delta_c = man_c[DELTA_W-1:0];
    end
  end

  // Handshake events for this cycle
  always_comb begin
    accept_c    = ivalid && iready_q;
    pop_c       = ovalid_q && oready;
    push_c      = sc_vld_q[SC_LEN-1];
    push_data_c = {lut_q, sc_delta_q[SC_LEN-1], sc_flags_q[SC_LEN-1]};
  end

  // Address stage: load on accept, otherwise hold address and drop read enable
  always_comb begin
    lut_address_d = lut_address_q;
    as_delta_d    = as_delta_q;
    as_flags_d    = as_flags_q;
    lut_rden_d    = accept_c;
    if (accept_c) begin
      lut_address_d = dec_addr_c;
      as_delta_d    = dec_delta_c;
      as_flags_d    = dec_flags_c;
    end
  end

  // Sidecar shift register tracking each ROM read until lut_q is valid
  always_comb begin
    sc_vld_d      = sc_vld_q;
    sc_delta_d    = sc_delta_q;
    sc_flags_d    = sc_flags_q;
    sc_vld_d[0]   = lut_rden_q;
    sc_delta_d[0] = as_delta_q;
    sc_flags_d[0] = as_flags_q;
    for (int unsigned i = 1; i < SC_LEN; i++) begin
      sc_vld_d[i]   = sc_vld_q[i-1];
      sc_delta_d[i] = sc_delta_q[i-1];
      sc_flags_d[i] = sc_flags_q[i-1];
    end
  end

  // FIFO pointers, credits and FWFT output registers
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = push_data_c;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d    = cnt_q + OCC_W'(push_c) - OCC_W'(pop_c);
    occ_d    = occ_q + OCC_W'(accept_c) - OCC_W'(pop_c);
    iready_d = (occ_d < OCC_W'(FIFO_DEPTH));
    ovalid_d = (cnt_d != '0);
    head_c   = mem_d[rd_ptr_d];
    ocoef_d  = ocoef_q;
    odelta_d = odelta_q;
    oflags_d = oflags_q;
    if (ovalid_d) begin
      {ocoef_d, odelta_d, oflags_d} = head_c;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lut_address_q <= '0;
      lut_rden_q    <= 1'b0;
      as_delta_q    <= '0;
      as_flags_q    <= '0;
      sc_vld_q      <= '0;
      for (int unsigned i = 0; i < SC_LEN; i++) begin
        sc_delta_q[i] <= '0;
        sc_flags_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
      iready_q <= 1'b0;
      ovalid_q <= 1'b0;
      ocoef_q  <= '0;
      odelta_q <= '0;
      oflags_q <= '0;
    end else begin
      lut_address_q <= lut_address_d;
      lut_rden_q    <= lut_rden_d;
      as_delta_q    <= as_delta_d;
      as_flags_q    <= as_flags_d;
      sc_vld_q      <= sc_vld_d;
      sc_delta_q    <= sc_delta_d;
      sc_flags_q    <= sc_flags_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      occ_q         <= occ_d;
      iready_q      <= iready_d;
      ovalid_q      <= ovalid_d;
      ocoef_q       <= ocoef_d;
      odelta_q      <= odelta_d;
      oflags_q      <= oflags_d;
    end
  end

  assign iready      = iready_q;
  assign lut_address = lut_address_q;
  assign lut_rden    = lut_rden_q;
  assign ovalid      = ovalid_q;
  assign ocoef       = ocoef_q;
  assign odelta      = odelta_q;
  assign oflags      = oflags_q;

endmodule

// File: tb/tb_lj_r2_lut_addr_gen.sv
// Directed bench for lj_r2_lut_addr_gen with a behavioural ROM.
module tb_lj_r2_lut_addr_gen;

  logic        clock;
  logic        resetn;
  logic        ivalid;
  logic        iready;
  logic [31:0] ir2;
  logic [11:0] lut_address;
  logic        lut_rden;
  logic [31:0] lut_q;
  logic        ovalid;
  logic        oready;
  logic [31:0] ocoef;
  logic [14:0] odelta;
  logic [1:0]  oflags;

  int errors = 0;
  int checks = 0;

  lj_r2_lut_addr_gen dut (
    .clock       (clock),
    .resetn      (resetn),
    .ivalid      (ivalid),
    .iready      (iready),
    .ir2         (ir2),
    .lut_address (lut_address),
    .lut_rden    (lut_rden),
    .lut_q       (lut_q),
    .ovalid      (ovalid),
    .oready      (oready),
    .ocoef       (ocoef),
    .odelta      (odelta),
    .oflags      (oflags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM content: distinct, address-derived pattern
  function automatic logic [31:0] rom_f(input logic [11:0] a);
    return {4'hA, a, 4'h5, ~a};
  endfunction

  // ROM model: data for an address registered at E0 is on lut_q after E0+3
  logic [11:0] rom_a1;
  logic [31:0] rom_d2;
  always @(posedge clock) begin
    rom_a1 <= lut_address;
    rom_d2 <= rom_f(rom_a1);
    lut_q  <= rom_d2;
  end

  // Reference for in-range r2: {coef, delta, flags}
  function automatic logic [48:0] model(input logic [31:0] r2);
    int unsigned e;
    logic [11:0] a;
    e = int'(r2[30:23]);
    a = 12'((e - 121) * 256 + int'(r2[22:15]));
    return {rom_f(a), r2[14:0], 2'b00};
  endfunction

  function automatic logic [31:0] rand_r2();
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'(121 + $urandom_range(0, 11));
    m = 23'($urandom());
    return {1'b0, e, m};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One isolated transaction with oready=1, checking address stage and 4-cycle latency
  task automatic send_one(input string tag, input logic [31:0] r2, input logic [11:0] ea,
                          input logic [14:0] ed, input logic [1:0] ef);
    chk({tag, "_iready"}, 64'(iready), 64'(1));
    ivalid = 1'b1;
    ir2    = r2;
    oready = 1'b1;
    step();
    ivalid = 1'b0;
    ir2    = 32'h4120_0000;
    chk({tag, "_addr"}, 64'(lut_address), 64'(ea));
    chk({tag, "_rden"}, 64'(lut_rden), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_early_ovalid"}, 64'(ovalid), 64'(0));
      if (k == 1) begin
        chk({tag, "_rden_drop"}, 64'(lut_rden), 64'(0));
        chk({tag, "_addr_hold"}, 64'(lut_address), 64'(ea));
      end
      step();
    end
    chk({tag, "_ovalid"}, 64'(ovalid), 64'(1));
    chk({tag, "_entry"}, 64'({ocoef, odelta, oflags}), 64'({rom_f(ea), ed, ef}));
    step();
  endtask

  logic [31:0] bp_r2 [4];
  logic [48:0] expq [$];
  logic [48:0] last_out;
  int          nacc;
  int          sent;
  int          got;
  int          occ_m;
  int          max_occ;
  logic        acc;
  logic        pop;

  initial begin
    resetn = 1'b0;
    ivalid = 1'b0;
    oready = 1'b0;
    ir2    = 32'h0;
    bp_r2[0] = 32'h3F80_0000;
    bp_r2[1] = 32'h4000_0000;
    bp_r2[2] = 32'h3E80_0000;
    bp_r2[3] = 32'h4200_0000;

    // Reset state
    step();
    step();
    chk("rst_addr",   64'(lut_address), 64'(0));
    chk("rst_rden",   64'(lut_rden),    64'(0));
    chk("rst_ovalid", 64'(ovalid),      64'(0));
    chk("rst_out",    64'({ocoef, odelta, oflags}), 64'(0));
    chk("rst_iready", 64'(iready),      64'(0));
    resetn = 1'b1;
    step();

    // Directed decode vectors
    send_one("one",      32'h3F80_0000, 12'd1536, 15'h0000, 2'b00);
    send_one("one_half", 32'h3FC0_0000, 12'd1664, 15'h0000, 2'b00);
    send_one("bin129",   32'h3FC0_C000, 12'd1665, 15'h4000, 2'b00);
    send_one("r2_64",    32'h4280_0000, 12'd0,    15'h0000, 2'b10);
    send_one("top",      32'h427F_FFFF, 12'd3071, 15'h7FFF, 2'b00);
    send_one("bottom",   32'h3C80_0000, 12'd0,    15'h0000, 2'b00);
    send_one("below",    32'h3C00_0000, 12'd0,    15'h0000, 2'b01);
    send_one("zero",     32'h0000_0000, 12'd0,    15'h0000, 2'b01);
    send_one("nan",      32'h7FC0_0000, 12'd0,    15'h0000, 2'b10);
    send_one("negative", 32'hBF80_0000, 12'd0,    15'h0000, 2'b01);

    // Hold behaviour once the FIFO drains
    chk("hold_ovalid", 64'(ovalid), 64'(0));
    chk("hold_out",    64'({ocoef, odelta, oflags}), 64'({rom_f(12'd0), 15'h0, 2'b01}));

    // Backpressure: exactly FIFO_DEPTH accepts with oready low
    nacc   = 0;
    oready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ivalid = 1'b1;
      ir2    = (nacc < 4) ? bp_r2[nacc] : 32'h4040_0000;
      if (iready) begin
        expq.push_back(model(ir2));
        nacc++;
      end
      step();
    end
    ivalid = 1'b0;
    chk("bp_accepts", 64'(nacc),   64'(4));
    chk("bp_iready",  64'(iready), 64'(0));
    chk("bp_ovalid",  64'(ovalid), 64'(1));
    oready = 1'b1;
    if (expq.size() > 0) chk("bp_first", 64'({ocoef, odelta, oflags}), 64'(expq.pop_front()));
    step();
    chk("bp_iready_back", 64'(iready), 64'(1));
    for (int c = 0; c < 10; c++) begin
      if (ovalid) begin
        if (expq.size() > 0) chk("bp_drain", 64'({ocoef, odelta, oflags}), 64'(expq.pop_front()));
        else chk("bp_extra_entry", 64'(ovalid), 64'(0));
      end
      step();
    end
    chk("bp_all_drained", 64'(expq.size()), 64'(0));
    chk("bp_idle", 64'(ovalid), 64'(0));

    // Streaming with random backpressure
    sent    = 0;
    got     = 0;
    occ_m   = 0;
    max_occ = 0;
    ir2     = rand_r2();
    for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
      oready = ($urandom_range(0, 1) == 1);
      ivalid = (sent < 100);
      acc    = ivalid && iready;
      pop    = ovalid && oready;
      if (pop) begin
        if (expq.size() > 0) begin
          last_out = expq.pop_front();
          chk("stream_out", 64'({ocoef, odelta, oflags}), 64'(last_out));
        end else begin
          chk("stream_extra_entry", 64'(ovalid), 64'(0));
        end
        got++;
      end
      if (acc) begin
        expq.push_back(model(ir2));
        sent++;
      end
      occ_m = occ_m + int'(acc) - int'(pop);
      if (occ_m > max_occ) max_occ = occ_m;
      step();
      if (acc) ir2 = rand_r2();
    end
    ivalid = 1'b0;
    oready = 1'b1;
    chk("stream_count", 64'(got), 64'(100));
    chk("stream_occ_bound", 64'(max_occ <= 4), 64'(1));
    step();
    chk("stream_idle", 64'(ovalid), 64'(0));

    // Reset with two entries buffered and two in flight
    oready = 1'b0;
    ivalid = 1'b1;
    ir2    = 32'h3F80_0000;
    step();
    ir2    = 32'h3FC0_0000;
    step();
    ivalid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("mid_buffered", 64'(ovalid), 64'(1));
    ivalid = 1'b1;
    ir2    = 32'h4000_0000;
    step();
    ir2    = 32'h4100_0000;
    step();
    ivalid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_ovalid", 64'(ovalid),      64'(0));
    chk("mid_rst_out",    64'({ocoef, odelta, oflags}), 64'(0));
    chk("mid_rst_addr",   64'(lut_address), 64'(0));
    chk("mid_rst_rden",   64'(lut_rden),    64'(0));
    chk("mid_rst_iready", 64'(iready),      64'(0));
    step();
    step();
    resetn = 1'b1;
    step();
    send_one("post_rst", 32'h3FC0_C000, 12'd1665, 15'h4000, 2'b00);
    for (int c = 0; c < 6; c++) begin
      chk("post_rst_no_stale", 64'(ovalid), 64'(0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
